// File: rtl/display_pkg.sv
// Shared display definitions: colour codes, scan states and the default
// screen geometry also used by the game logic.
package display_pkg;

  localparam int DEFAULT_WIDTH  = 160;
  localparam int DEFAULT_HEIGHT = 120;

  // 3-bit DE2 VGA colour codes, {r, g, b}
  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_RED   = 3'b100;
  localparam logic [2:0] COL_GREEN = 3'b010;
  localparam logic [2:0] COL_BLUE  = 3'b001;

  // Kind of frame currently being scanned out
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_DRAW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/display_scanner_if.sv
// Pixel-write bus from the scanner to the VGA adapter, plus frame status.
interface display_scanner_if #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CW = 3
);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] colour;
  logic          plot;
  logic          frame_done;
  logic          clearing;

  modport master (output x, y, colour, plot, frame_done, clearing);
  modport slave  (input  x, y, colour, plot, frame_done, clearing);

endinterface

// File: rtl/raster_counter.sv
// Raster position counter: cx runs along a line, cy steps once per line,
// both wrap at the end of the frame. Advances only while enable is high.
module raster_counter #(
  parameter  int WIDTH  = 160,
  parameter  int HEIGHT = 120,
  localparam int XW     = $clog2(WIDTH),
  localparam int YW     = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          enable,
  output logic [XW-1:0] cx,
  output logic [YW-1:0] cy,
  output logic          at_origin,
  output logic          at_last
);

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  // Step the raster position, wrapping line and frame without any division
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cx <= {XW{1'b0}};
      cy <= {YW{1'b0}};
    end else if (enable) begin
      if (cx == X_LAST) begin
        cx <= {XW{1'b0}};
        if (cy == Y_LAST) begin
          cy <= {YW{1'b0}};
        end else begin
          cy <= cy + YW'(1);
        end
      end else begin
        cx <= cx + XW'(1);
      end
    end else begin
      cx <= cx;
      cy <= cy;
    end
  end

  assign at_origin = (cx == {XW{1'b0}}) && (cy == {YW{1'b0}});
  assign at_last   = (cx == X_LAST) && (cy == Y_LAST);

endmodule

// File: rtl/display_scanner.sv
// Raster scanner for the VGA adapter write port. Walks every pixel of the
// frame, drawing either a black clear frame or the sprites over the bullet
// grid. Sprite inputs are snapshotted at the frame origin so a frame never
// shows a half-moved sprite.
module display_scanner
  import display_pkg::*;
#(
  parameter  int            WIDTH       = DEFAULT_WIDTH,
  parameter  int            HEIGHT      = DEFAULT_HEIGHT,
  parameter  int            NUM_SPRITES = 2,
  parameter  int            CW          = 3,
  parameter  logic [CW-1:0] GRID_COLOUR = CW'(COL_GREEN),
  localparam int            XW          = $clog2(WIDTH),
  localparam int            YW          = $clog2(HEIGHT)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      enable,
  input  logic                      clear_req,
  input  logic [NUM_SPRITES-1:0]    sprite_en,
  input  logic [NUM_SPRITES*XW-1:0] sprite_x,
  input  logic [NUM_SPRITES*YW-1:0] sprite_y,
  input  logic [NUM_SPRITES*CW-1:0] sprite_colour,
  input  logic [WIDTH*HEIGHT-1:0]   grid,
  display_scanner_if.master         px_bus
);

  localparam int GW = $clog2(WIDTH * HEIGHT);

  logic [XW-1:0] cx_s;
  logic [YW-1:0] cy_s;
  logic          at_origin_s;
  logic          at_last_s;
  logic          frame_end_s;

  scan_state_e   state_r, state_next_s;
  logic          pending_r, pending_next_s;

  logic [NUM_SPRITES-1:0]    snap_en_r;
  logic [NUM_SPRITES*XW-1:0] snap_x_r;
  logic [NUM_SPRITES*YW-1:0] snap_y_r;
  logic [NUM_SPRITES*CW-1:0] snap_c_r;

  logic [NUM_SPRITES-1:0]    use_en_s;
  logic [NUM_SPRITES*XW-1:0] use_x_s;
  logic [NUM_SPRITES*YW-1:0] use_y_s;
  logic [NUM_SPRITES*CW-1:0] use_c_s;

  logic [GW-1:0] grid_idx_s;
  logic [CW-1:0] draw_colour_s;

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_raster_counter (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (enable),
    .cx        (cx_s),
    .cy        (cy_s),
    .at_origin (at_origin_s),
    .at_last   (at_last_s)
  );

  assign frame_end_s = enable && at_last_s;

  // Frame-type register and latched clear request
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= ST_CLEAR;
      pending_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      pending_r <= pending_next_s;
    end
  end

  // Choose the next frame type at frame end; a request arriving on that very
  // cycle still counts for the following frame
  always_comb begin
    state_next_s   = state_r;
    pending_next_s = pending_r || clear_req;
    if (frame_end_s) begin
      pending_next_s = 1'b0;
      if (pending_r || clear_req) begin
        state_next_s = ST_CLEAR;
      end else begin
        state_next_s = ST_DRAW;
      end
    end else begin
      state_next_s = state_r;
    end
  end

  // Capture the sprite table at the first enabled cycle of each frame
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      snap_en_r <= {NUM_SPRITES{1'b0}};
      snap_x_r  <= {(NUM_SPRITES*XW){1'b0}};
      snap_y_r  <= {(NUM_SPRITES*YW){1'b0}};
      snap_c_r  <= {(NUM_SPRITES*CW){1'b0}};
    end else if (enable && at_origin_s) begin
      snap_en_r <= sprite_en;
      snap_x_r  <= sprite_x;
      snap_y_r  <= sprite_y;
      snap_c_r  <= sprite_colour;
    end else begin
      snap_en_r <= snap_en_r;
      snap_x_r  <= snap_x_r;
      snap_y_r  <= snap_y_r;
      snap_c_r  <= snap_c_r;
    end
  end

  // The origin pixel is drawn from the live inputs being captured this cycle
  assign use_en_s = at_origin_s ? sprite_en     : snap_en_r;
  assign use_x_s  = at_origin_s ? sprite_x      : snap_x_r;
  assign use_y_s  = at_origin_s ? sprite_y      : snap_y_r;
  assign use_c_s  = at_origin_s ? sprite_colour : snap_c_r;

  // Priority mux: lowest-index matching sprite, then bullet grid, then black.
  // Scanning from the highest index down lets lower slots overwrite.
  always_comb begin
    grid_idx_s    = GW'(cy_s) * GW'(WIDTH) + GW'(cx_s);
    draw_colour_s = grid[grid_idx_s] ? GRID_COLOUR : {CW{1'b0}};
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      draw_colour_s = (use_en_s[i] &&
                       (use_x_s[i*XW +: XW] == cx_s) &&
                       (use_y_s[i*YW +: YW] == cy_s)) ? use_c_s[i*CW +: CW]
                                                      : draw_colour_s;
    end
  end

  // Registered pixel bus, one cycle behind the counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      px_bus.x          <= {XW{1'b0}};
      px_bus.y          <= {YW{1'b0}};
      px_bus.colour     <= {CW{1'b0}};
      px_bus.plot       <= 1'b0;
      px_bus.frame_done <= 1'b0;
      px_bus.clearing   <= 1'b1;
    end else begin
      px_bus.x          <= cx_s;
      px_bus.y          <= cy_s;
      px_bus.colour     <= (state_r == ST_DRAW) ? draw_colour_s : {CW{1'b0}};
      px_bus.plot       <= enable;
      px_bus.frame_done <= frame_end_s;
      px_bus.clearing   <= (state_r == ST_CLEAR);
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Randomised self-checking bench for display_scanner on an 8x4 screen, with
// a second default-size instance used to measure the frame period.
module tb_display_scanner;
  import display_pkg::*;

  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetn, enable, clear_req;
  logic [1:0]   s_en;
  logic [2:0]   s_x [2];
  logic [1:0]   s_y [2];
  logic [2:0]   s_c [2];
  logic [N-1:0] grid;
  logic [5:0]   sx_bus;
  logic [3:0]   sy_bus;
  logic [5:0]   sc_bus;
  logic [160*120-1:0] grid2;

  assign sx_bus = {s_x[1], s_x[0]};
  assign sy_bus = {s_y[1], s_y[0]};
  assign sc_bus = {s_c[1], s_c[0]};
  assign grid2  = '0;

  display_scanner_if #(.XW(3), .YW(2), .CW(3)) pb ();
  display_scanner_if #(.XW(8), .YW(7), .CW(3)) pb2 ();

  display_scanner #(.WIDTH(W), .HEIGHT(H), .NUM_SPRITES(2), .CW(3),
                    .GRID_COLOUR(COL_GREEN)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .clear_req(clear_req),
    .sprite_en(s_en), .sprite_x(sx_bus), .sprite_y(sy_bus),
    .sprite_colour(sc_bus), .grid(grid), .px_bus(pb));

  display_scanner dut2 (
    .clk(clk), .resetn(resetn), .enable(1'b1), .clear_req(1'b0),
    .sprite_en(2'b00), .sprite_x(16'h0000), .sprite_y(14'h0000),
    .sprite_colour(6'h00), .grid(grid2), .px_bus(pb2));

  // observed bus: x[10:8] y[7:6] colour[5:3] plot[2] frame_done[1] clearing[0]
  logic [10:0] obs;
  assign obs = {pb.x, pb.y, pb.colour, pb.plot, pb.frame_done, pb.clearing};
  localparam logic [10:0] RESET_VEC = 11'b000_00_000_0_0_1;

  int total = 0;
  int bad   = 0;

  // reference model: linear pixel index, frame kind, pending request, snapshot
  int          pix;
  logic        m_clear, m_pend;
  logic [1:0]  m_en;
  logic [2:0]  m_x [2];
  logic [1:0]  m_y [2];
  logic [2:0]  m_c [2];
  logic [10:0] exp_vec, exp_mask;

  task automatic model_reset();
    pix = 0; m_clear = 1'b1; m_pend = 1'b0; m_en = 2'b00;
    for (int i = 0; i < 2; i++) begin
      m_x[i] = 3'd0; m_y[i] = 2'd0; m_c[i] = 3'd0;
    end
  endtask

  // Predict the output of the coming edge from current inputs, then clock.
  task automatic tick();
    int px, py;
    logic [1:0] ue;
    logic [2:0] ux [2];
    logic [1:0] uy [2];
    logic [2:0] uc [2];
    logic [2:0] col;
    logic hit;
    px = pix % W;
    py = pix / W;
    if (pix == 0) begin
      ue = s_en; ux = s_x; uy = s_y; uc = s_c;
    end else begin
      ue = m_en; ux = m_x; uy = m_y; uc = m_c;
    end
    col = COL_BLACK;
    hit = 1'b0;
    if (!m_clear) begin
      for (int i = 0; i < 2; i++) begin
        if (!hit && ue[i] && int'(ux[i]) == px && int'(uy[i]) == py) begin
          hit = 1'b1;
          col = uc[i];
        end
      end
      if (!hit && grid[pix]) col = COL_GREEN;
    end
    exp_mask = enable ? 11'h7ff : 11'h006;
    exp_vec  = {3'(px), 2'(py), col, enable, enable && (pix == N - 1), m_clear} & exp_mask;
    if (enable && pix == 0) begin
      m_en = s_en; m_x = s_x; m_y = s_y; m_c = s_c;
    end
    if (clear_req) m_pend = 1'b1;
    if (enable && pix == N - 1) begin
      m_clear = m_pend;
      m_pend  = 1'b0;
    end
    if (enable) pix = (pix + 1) % N;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b0; clear_req = 1'b0; s_en = 2'b00;
    for (int i = 0; i < 2; i++) begin
      s_x[i] = 3'd0; s_y[i] = 2'd0; s_c[i] = 3'd0;
    end
    grid = '1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs !== RESET_VEC) begin
      bad++; $display("FAIL reset_state got=%h want=%h", obs, RESET_VEC);
    end
    total++;
    if (pb2.clearing !== 1'b1 || pb2.plot !== 1'b0) begin
      bad++; $display("FAIL reset_state_default got=%b%b want=10", pb2.clearing, pb2.plot);
    end
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_clear_then_green();
    int n_clear, n_green, n_fd;
    n_clear = 0; n_green = 0; n_fd = 0;
    enable = 1'b1; grid = '1; s_en = 2'b00;
    for (int k = 0; k < 2 * N; k++) begin
      tick();
      total++;
      if ((obs & exp_mask) !== exp_vec) begin
        bad++; $display("FAIL clear_then_green k=%0d got=%h want=%h", k, obs & exp_mask, exp_vec);
      end
      if (pb.plot && pb.clearing && pb.colour == COL_BLACK) n_clear++;
      if (pb.plot && !pb.clearing && pb.colour == COL_GREEN) n_green++;
      if (pb.frame_done && pb.x == 3'd7 && pb.y == 2'd3) n_fd++;
    end
    total++;
    if (n_clear != N || n_green != N || n_fd != 2) begin
      bad++; $display("FAIL clear_then_green_counts got=%0d/%0d/%0d want=32/32/2", n_clear, n_green, n_fd);
    end
  endtask

  task automatic test_priority();
    logic [2:0] seen [2];
    grid = N'($urandom);
    s_en = 2'b11;
    s_x[0] = 3'd2; s_y[0] = 2'd1; s_c[0] = COL_RED;
    s_x[1] = 3'd2; s_y[1] = 2'd1; s_c[1] = COL_BLUE;
    for (int f = 0; f < 2; f++) begin
      if (f == 1) s_en = 2'b10;
      seen[f] = 3'd7;
      for (int k = 0; k < N; k++) begin
        tick();
        total++;
        if ((obs & exp_mask) !== exp_vec) begin
          bad++; $display("FAIL priority f=%0d k=%0d got=%h want=%h", f, k, obs & exp_mask, exp_vec);
        end
        if (pb.plot && pb.x == 3'd2 && pb.y == 2'd1) seen[f] = pb.colour;
      end
    end
    total++;
    if (seen[0] !== COL_RED || seen[1] !== COL_BLUE) begin
      bad++; $display("FAIL priority_pixel got=%0d,%0d want=%0d,%0d", seen[0], seen[1], COL_RED, COL_BLUE);
    end
  endtask

  task automatic test_snapshot();
    int red_a_old, red_a_other, red_b_new, red_b_other;
    red_a_old = 0; red_a_other = 0; red_b_new = 0; red_b_other = 0;
    grid = '0; s_en = 2'b01;
    s_x[0] = 3'd2; s_y[0] = 2'd1; s_c[0] = COL_RED;
    for (int k = 0; k < 2 * N; k++) begin
      if (k == 2 * W) begin
        s_x[0] = 3'd5; s_y[0] = 2'd2;
      end
      tick();
      total++;
      if ((obs & exp_mask) !== exp_vec) begin
        bad++; $display("FAIL snapshot k=%0d got=%h want=%h", k, obs & exp_mask, exp_vec);
      end
      if (pb.plot && pb.colour == COL_RED) begin
        if (k < N) begin
          if (pb.x == 3'd2 && pb.y == 2'd1) red_a_old++; else red_a_other++;
        end else begin
          if (pb.x == 3'd5 && pb.y == 2'd2) red_b_new++; else red_b_other++;
        end
      end
    end
    total++;
    if (red_a_old != 1 || red_a_other != 0 || red_b_new != 1 || red_b_other != 0) begin
      bad++; $display("FAIL snapshot_red got=%0d/%0d/%0d/%0d want=1/0/1/0",
                      red_a_old, red_a_other, red_b_new, red_b_other);
    end
  endtask

  task automatic test_enable_gap();
    int idle, plots, dups, first_x, first_y;
    logic [N-1:0] seen;
    idle = 0; plots = 0; dups = 0; seen = '0; first_x = -1; first_y = -1;
    grid = N'($urandom); s_en = 2'b00;
    for (int k = 0; k < N + 5; k++) begin
      enable = (k >= 12 && k < 17) ? 1'b0 : 1'b1;
      tick();
      total++;
      if ((obs & exp_mask) !== exp_vec) begin
        bad++; $display("FAIL enable_gap k=%0d got=%h want=%h", k, obs & exp_mask, exp_vec);
      end
      if (!pb.plot) idle++;
      if (pb.plot) begin
        plots++;
        if (seen[int'(pb.y) * W + int'(pb.x)]) dups++;
        seen[int'(pb.y) * W + int'(pb.x)] = 1'b1;
        if (k == 17) begin
          first_x = int'(pb.x); first_y = int'(pb.y);
        end
      end
    end
    enable = 1'b1;
    total++;
    if (idle != 5 || plots != N || dups != 0 || seen !== '1 || first_x != 4 || first_y != 1) begin
      bad++; $display("FAIL enable_gap_frame got=idle%0d plots%0d dups%0d resume(%0d,%0d) want=idle5 plots32 dups0 resume(4,1)",
                      idle, plots, dups, first_x, first_y);
    end
  endtask

  task automatic test_clear_req();
    logic [5:0] kinds;
    logic [5:0] want;
    kinds = '0; want = 6'b010110;
    grid = N'($urandom); s_en = 2'b11;
    s_x[0] = 3'd1; s_y[0] = 2'd0; s_c[0] = COL_RED;
    s_x[1] = 3'd6; s_y[1] = 2'd3; s_c[1] = COL_BLUE;
    for (int k = 0; k < 6 * N; k++) begin
      clear_req = (k == 10 || k == N + 5 || k == N + 15 || k == 4 * N - 1) ? 1'b1 : 1'b0;
      tick();
      total++;
      if ((obs & exp_mask) !== exp_vec) begin
        bad++; $display("FAIL clear_req k=%0d got=%h want=%h", k, obs & exp_mask, exp_vec);
      end
      if (k % N == 0) kinds[k / N] = pb.clearing;
    end
    clear_req = 1'b0;
    total++;
    if (kinds !== want) begin
      bad++; $display("FAIL clear_req_frames got=%b want=%b", kinds, want);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      enable    = ($urandom_range(0, 4) != 0);
      clear_req = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) begin
        s_en = 2'($urandom);
        for (int i = 0; i < 2; i++) begin
          s_x[i] = 3'($urandom); s_y[i] = 2'($urandom); s_c[i] = 3'($urandom);
        end
      end
      if ($urandom_range(0, 7) == 0) grid = N'($urandom);
      tick();
      total++;
      if ((obs & exp_mask) !== exp_vec) begin
        bad++; $display("FAIL random k=%0d got=%h want=%h", k, obs & exp_mask, exp_vec);
      end
    end
    enable = 1'b1; clear_req = 1'b0;
    for (int k = 0; k < N && pix != 0; k++) begin
      tick();
      total++;
      if ((obs & exp_mask) !== exp_vec) begin
        bad++; $display("FAIL random_tail k=%0d got=%h want=%h", k, obs & exp_mask, exp_vec);
      end
    end
  endtask

  task automatic test_mid_reset();
    int n_clear;
    n_clear = 0;
    enable = 1'b1; grid = '1; s_en = 2'b00;
    for (int k = 0; k < 21; k++) begin
      tick();
      total++;
      if ((obs & exp_mask) !== exp_vec) begin
        bad++; $display("FAIL mid_reset_pre k=%0d got=%h want=%h", k, obs & exp_mask, exp_vec);
      end
    end
    resetn = 1'b0;
    #1;
    total++;
    if (obs !== RESET_VEC) begin
      bad++; $display("FAIL mid_reset_async got=%h want=%h", obs, RESET_VEC);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();
    for (int k = 0; k < N; k++) begin
      tick();
      total++;
      if ((obs & exp_mask) !== exp_vec) begin
        bad++; $display("FAIL mid_reset_post k=%0d got=%h want=%h", k, obs & exp_mask, exp_vec);
      end
      if (pb.plot && pb.clearing && pb.colour == COL_BLACK) n_clear++;
    end
    total++;
    if (n_clear != N) begin
      bad++; $display("FAIL mid_reset_clear_frame got=%0d want=%0d", n_clear, N);
    end
  endtask

  task automatic test_default_frame();
    int t0, t1, n, last_ok;
    t0 = -1; t1 = -1; n = 0; last_ok = 1;
    for (int c = 0; c < 40000 && n < 2; c++) begin
      @(posedge clk);
      #1;
      if (pb2.frame_done) begin
        if (pb2.x !== 8'd159 || pb2.y !== 7'd119 || pb2.plot !== 1'b1) last_ok = 0;
        if (n == 0) t0 = c; else t1 = c;
        n++;
      end
    end
    total++;
    if (n < 2 || (t1 - t0) != 160 * 120 || last_ok != 1) begin
      bad++; $display("FAIL default_frame_period got=pulses%0d period%0d pos_ok%0d want=pulses2 period19200 pos_ok1",
                      n, t1 - t0, last_ok);
    end
  endtask

  initial begin
    test_reset();
    test_clear_then_green();
    test_priority();
    test_snapshot();
    test_enable_gap();
    test_clear_req();
    test_random();
    test_mid_reset();
    test_default_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
